// File: rtl/decoder_scan.sv
// Binary-to-one-hot decoder with a direct (handshaked) mode and an auto-scan mode
// that walks every output in turn with a programmable dwell time and blanking gap.
module decoder_scan #(
    parameter int unsigned SEL_W = 3,
    parameter int unsigned DWELL = 4,
    parameter int unsigned BLANK = 1
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    en,
    input  logic                    mode,
    input  logic                    sel_valid,
    input  logic [SEL_W-1:0]        sel,
    output logic                    sel_ready,
    output logic [(2**SEL_W)-1:0]   out,
    output logic [SEL_W-1:0]        idx,
    output logic                    wrap
);

    localparam int unsigned N   = 2 ** SEL_W;
    localparam int unsigned DCW = $clog2(DWELL + 1);
    localparam int unsigned BCW = (BLANK > 0) ? $clog2(BLANK + 1) : 1;

    localparam logic [DCW-1:0] DWELL_LAST = DCW'(DWELL - 1);
    localparam logic [BCW-1:0] BLANK_LAST = BCW'((BLANK > 0) ? (BLANK - 1) : 0);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        DIRECT   = 2'd1,
        HOLD     = 2'd2,
        BLANK_ST = 2'd3
    } state_e;

    state_e             state_q, state_d;
    logic [N-1:0]       out_q, out_d;
    logic [SEL_W-1:0]   idx_q, idx_d;
    logic               wrap_q, wrap_d;
    logic               sel_ready_q, sel_ready_d;
    logic [DCW-1:0]     dwell_q, dwell_d;
    logic [BCW-1:0]     blank_q, blank_d;
    logic               advance;

    function automatic logic [N-1:0] onehot(input logic [SEL_W-1:0] code);
        logic [N-1:0] v;
        v       = '0;
        v[code] = 1'b1;
        return v;
    endfunction

    // State and output registers; every output comes straight from a flop.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            out_q       <= '0;
            idx_q       <= '0;
            wrap_q      <= 1'b0;
            sel_ready_q <= 1'b0;
            dwell_q     <= '0;
            blank_q     <= '0;
        end else begin
            state_q     <= state_d;
            out_q       <= out_d;
            idx_q       <= idx_d;
            wrap_q      <= wrap_d;
            sel_ready_q <= sel_ready_d;
            dwell_q     <= dwell_d;
            blank_q     <= blank_d;
        end
    end

    // Next state plus the values the outputs will show alongside it.
    always_comb begin
        state_d = state_q;
        out_d   = out_q;
        idx_d   = idx_q;
        wrap_d  = 1'b0;
        dwell_d = dwell_q;
        blank_d = blank_q;
        advance = 1'b0;

        if (!en) begin
            state_d = IDLE;
            out_d   = '0;
            idx_d   = '0;
            dwell_d = '0;
            blank_d = '0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    out_d   = '0;
                    idx_d   = '0;
                    dwell_d = '0;
                    blank_d = '0;
                    if (mode) begin
                        state_d = HOLD;
                        out_d   = onehot('0);
                    end else begin
                        state_d = DIRECT;
                    end
                end

                DIRECT: begin
                    // A mode switch outranks a handshake offered in the same cycle.
                    if (mode) begin
                        state_d = HOLD;
                        idx_d   = '0;
                        out_d   = onehot('0);
                        dwell_d = '0;
                        blank_d = '0;
                    end else if (sel_valid && sel_ready_q) begin
                        idx_d = sel;
                        out_d = onehot(sel);
                    end
                end

                HOLD: begin
                    if (!mode) begin
                        state_d = DIRECT;
                        out_d   = '0;
                        idx_d   = '0;
                        dwell_d = '0;
                        blank_d = '0;
                    end else if (dwell_q == DWELL_LAST) begin
                        dwell_d = '0;
                        if (BLANK > 0) begin
                            state_d = BLANK_ST;
                            out_d   = '0;
                            blank_d = '0;
                        end else begin
                            advance = 1'b1;
                        end
                    end else begin
                        dwell_d = dwell_q + DCW'(1);
                    end
                end

                BLANK_ST: begin
                    if (!mode) begin
                        state_d = DIRECT;
                        out_d   = '0;
                        idx_d   = '0;
                        dwell_d = '0;
                        blank_d = '0;
                    end else if (blank_q == BLANK_LAST) begin
                        advance = 1'b1;
                    end else begin
                        blank_d = blank_q + BCW'(1);
                    end
                end

                default: begin
                    state_d = IDLE;
                    out_d   = '0;
                    idx_d   = '0;
                    dwell_d = '0;
                    blank_d = '0;
                end
            endcase

            // Step to the next output; the index rolls over naturally at N.
            if (advance) begin
                state_d = HOLD;
                idx_d   = idx_q + SEL_W'(1);
                out_d   = onehot(idx_q + SEL_W'(1));
                wrap_d  = &idx_q;
                dwell_d = '0;
                blank_d = '0;
            end
        end

        sel_ready_d = (state_d == DIRECT);
    end

    assign out       = out_q;
    assign idx       = idx_q;
    assign wrap      = wrap_q;
    assign sel_ready = sel_ready_q;

endmodule

// File: tb/tb_decoder_scan.sv
// Bench for decoder_scan: two builds (BLANK=1 and BLANK=0, both DWELL=2) driven in
// parallel and compared every cycle against a timeline-based reference model.
module tb_decoder_scan;

    localparam int SW = 3;
    localparam int N  = 8;
    localparam int DW = 2;

    logic           clk;
    logic           rst_n;
    logic           en;
    logic           mode;
    logic           sel_valid;
    logic [SW-1:0]  sel;

    logic           rdy1, wrap1, rdy0, wrap0;
    logic [N-1:0]   out1, out0;
    logic [SW-1:0]  idx1, idx0;

    int tests = 0;
    int fails = 0;

    decoder_scan #(.SEL_W(SW), .DWELL(DW), .BLANK(1)) dut (
        .clk(clk), .rst_n(rst_n), .en(en), .mode(mode), .sel_valid(sel_valid),
        .sel(sel), .sel_ready(rdy1), .out(out1), .idx(idx1), .wrap(wrap1)
    );

    decoder_scan #(.SEL_W(SW), .DWELL(DW), .BLANK(0)) dut0 (
        .clk(clk), .rst_n(rst_n), .en(en), .mode(mode), .sel_valid(sel_valid),
        .sel(sel), .sel_ready(rdy0), .out(out0), .idx(idx0), .wrap(wrap0)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: activity kind, cycles elapsed in scan, last accepted code.
    typedef enum {M_OFF, M_DIR, M_SCAN} mkind_e;
    mkind_e mk[2];
    int     mt[2];
    int     mcode[2];
    int     bl[2] = '{1, 0};

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic void model_reset();
        for (int k = 0; k < 2; k++) begin
            mk[k] = M_OFF; mt[k] = 0; mcode[k] = -1;
        end
    endfunction

    function automatic void model_step();
        for (int k = 0; k < 2; k++) begin
            if (!en) begin
                mk[k] = M_OFF; mcode[k] = -1;
            end else begin
                case (mk[k])
                    M_OFF: begin
                        if (mode) begin mk[k] = M_SCAN; mt[k] = 0; end
                        else begin mk[k] = M_DIR; mcode[k] = -1; end
                    end
                    M_DIR: begin
                        if (mode) begin mk[k] = M_SCAN; mt[k] = 0; end
                        else if (sel_valid) mcode[k] = int'(sel);
                    end
                    default: begin
                        if (!mode) begin mk[k] = M_DIR; mcode[k] = -1; end
                        else mt[k] = mt[k] + 1;
                    end
                endcase
            end
        end
    endfunction

    // Scan outputs follow from elapsed time: each step lasts DWELL+BLANK cycles.
    function automatic void model_expect(input int k, output logic [N-1:0] eo,
                                         output logic [SW-1:0] ei, output logic ew,
                                         output logic er);
        int p, stp, ph;
        logic [N-1:0] one;
        one = 1;
        eo = '0; ei = '0; ew = 1'b0; er = 1'b0;
        case (mk[k])
            M_DIR: begin
                er = 1'b1;
                if (mcode[k] >= 0) begin
                    eo = one << mcode[k];
                    ei = SW'(mcode[k]);
                end
            end
            M_SCAN: begin
                p   = DW + bl[k];
                stp = mt[k] / p;
                ph  = mt[k] % p;
                ei  = SW'(stp % N);
                if (ph < DW) eo = one << (stp % N);
                ew  = (ph == 0) && (stp > 0) && (stp % N == 0);
            end
            default: ;
        endcase
    endfunction

    task automatic check_all();
        logic [N-1:0]  eo, oo;
        logic [SW-1:0] ei, oi;
        logic          ew, er, ow, orr;
        for (int k = 0; k < 2; k++) begin
            model_expect(k, eo, ei, ew, er);
            oo  = (k == 0) ? out1 : out0;
            oi  = (k == 0) ? idx1 : idx0;
            ow  = (k == 0) ? wrap1 : wrap0;
            orr = (k == 0) ? rdy1 : rdy0;
            chk($sformatf("out_b%0d", bl[k]), 64'(oo), 64'(eo));
            chk($sformatf("idx_b%0d", bl[k]), 64'(oi), 64'(ei));
            chk($sformatf("wrap_b%0d", bl[k]), 64'(ow), 64'(ew));
            chk($sformatf("sel_ready_b%0d", bl[k]), 64'(orr), 64'(er));
            chk($sformatf("onehot0_b%0d", bl[k]), 64'($countones(oo) <= 1), 64'(1));
        end
    endtask

    task automatic step();
        model_step();
        @(posedge clk);
        #1;
        check_all();
    endtask

    logic [N-1:0] seq1 [4] = '{8'h01, 8'h01, 8'h00, 8'h02};
    logic [N-1:0] seq0 [4] = '{8'h01, 8'h01, 8'h02, 8'h02};

    initial begin
        int wraps;
        bit found;

        rst_n = 1'b0; en = 1'b1; mode = 1'b1; sel_valid = 1'b0; sel = '0;
        model_reset();
        #3;
        check_all();
        chk("rst_out_async", 64'(out1), 64'h0);
        repeat (2) @(posedge clk);
        #1;
        check_all();
        rst_n = 1'b1;

        // Scan start after reset, both builds
        for (int i = 0; i < 4; i++) begin
            step();
            chk($sformatf("start_seq_b1_%0d", i), 64'(out1), 64'(seq1[i]));
            chk($sformatf("start_seq_b0_%0d", i), 64'(out0), 64'(seq0[i]));
        end

        // Full scan revolution: exactly one wrap, coincident with bit 0 returning
        wraps = 0;
        for (int i = 0; i < 24; i++) begin
            step();
            if (wrap1) begin
                wraps++;
                chk("wrap_out", 64'(out1), 64'h01);
            end
        end
        chk("wrap_count", 64'(wraps), 64'd1);

        // Drop en while holding index 3
        found = 1'b0;
        for (int i = 0; i < 60 && !found; i++) begin
            if (idx1 == 3'd3 && out1 != '0) found = 1'b1;
            else step();
        end
        chk("find_idx3", 64'(found), 64'd1);
        en = 1'b0;
        step();
        chk("en_off_out", 64'(out1), 64'h0);
        chk("en_off_idx", 64'(idx1), 64'h0);
        en = 1'b1;
        step();
        chk("restart_out", 64'(out1), 64'h01);
        chk("restart_wrap", 64'(wrap1), 64'h0);

        // Leave scan at index 6, then a direct handshake
        found = 1'b0;
        for (int i = 0; i < 60 && !found; i++) begin
            if (idx1 == 3'd6 && out1 != '0) found = 1'b1;
            else step();
        end
        chk("find_idx6", 64'(found), 64'd1);
        mode = 1'b0;
        step();
        chk("mode_exit_out", 64'(out1), 64'h0);
        chk("mode_exit_ready", 64'(rdy1), 64'h1);
        sel = 3'd2; sel_valid = 1'b1;
        step();
        chk("direct_sel2", 64'(out1), 64'h04);

        // Direct decode of 5, then hold without handshakes
        sel = 3'd5;
        step();
        chk("direct_sel5_out", 64'(out1), 64'h20);
        chk("direct_sel5_idx", 64'(idx1), 64'd5);
        sel_valid = 1'b0; sel = 3'd1;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("direct_hold", 64'(out1), 64'h20);
        end

        // Mode switch wins over a simultaneous sel_valid
        mode = 1'b1; sel_valid = 1'b1; sel = 3'd7;
        step();
        chk("mode_prio_out", 64'(out1), 64'h01);
        chk("mode_prio_idx", 64'(idx1), 64'h0);
        sel_valid = 1'b0;

        // Randomized traffic with occasional asynchronous resets
        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(0, 199) == 0) begin
                rst_n = 1'b0;
                model_reset();
                #1;
                check_all();
                #1;
                rst_n = 1'b1;
            end
            en = ($urandom_range(0, 39) != 0);
            if ($urandom_range(0, 29) == 0) mode = ~mode;
            sel_valid = 1'($urandom_range(0, 1));
            sel       = SW'($urandom_range(0, N - 1));
            step();
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/decoder_scan.md
DECODER_SCAN -- requirements
Module: decoder_scan

Interface
REQ-001 SHALL have parameter SEL_W, default 3: select width; output count N = 2**SEL_W; legal range 1..6.
REQ-002 SHALL have parameter DWELL, default 4: cycles each output is held high in scan mode; legal range >=1.
REQ-003 SHALL have parameter BLANK, default 1: all-zero dead cycles between scan steps; legal range >=0.
REQ-004 SHALL have one clock; reset SHALL be asynchronous and active-low.
REQ-005 clk  input  1  sole clock, rising edge.
REQ-006 rst_n  input  1  asynchronous active-low reset.
REQ-007 en  input  1  global enable; 0 forces all outputs low.
REQ-008 mode  input  1  0 = direct decode, 1 = auto-scan.
REQ-009 sel_valid  input  1  sel carries a new code (direct mode).
REQ-010 sel  input  SEL_W  binary code to decode.
REQ-011 sel_ready  output  1  block accepts sel this cycle.
REQ-012 out  output  N  registered one-hot (or all-zero) decode output.
REQ-013 idx  output  SEL_W  index of the currently or most recently driven output.
REQ-014 wrap  output  1  one-cycle pulse when scan wraps to index 0.

Function
REQ-015 SHALL have FSM states IDLE, DIRECT, HOLD, BLANK_ST; all outputs registered.
REQ-016 IDLE: out=0, sel_ready=0. en=1&mode=0 -> DIRECT; en=1&mode=1 -> HOLD with idx=0.
REQ-017 DIRECT: sel_ready=1; on sel_valid&sel_ready, out = 1<<sel and idx = sel on the next rising edge (latency 1); without a handshake, out holds its value.
REQ-018 On entry to DIRECT, out SHALL be 0 until the first accepted sel.
REQ-019 HOLD: sel_ready=0; out = 1<<idx for exactly DWELL cycles, counted by an internal dwell counter (width clog2(DWELL+1)).
REQ-020 After DWELL cycles: BLANK>0 -> BLANK_ST with out=0 for exactly BLANK cycles, then HOLD with idx+1; BLANK=0 -> directly to HOLD with idx+1 (no zero gap).
REQ-021 idx increment SHALL be modulo N; on N-1 -> 0, wrap=1 for the one cycle in which out first shows bit 0; wrap=0 otherwise, including the initial entry to scan.
REQ-022 The first HOLD after entering scan SHALL show out[0]=1 on the cycle after entry is decided.
REQ-023 en=0 in any state -> IDLE next cycle: out=0, wrap=0, sel_ready=0, counters cleared, idx=0.
REQ-024 mode 1->0 while in HOLD/BLANK_ST -> DIRECT next cycle with out=0; the scan position is discarded.
REQ-025 mode 0->1 while in DIRECT -> HOLD at idx=0; a sel_valid in the same cycle SHALL be ignored.
REQ-026 Priority SHALL be: rst_n > en=0 > mode change > handshake/scan progress.
REQ-027 out SHALL never have more than one bit set in any cycle.

Reset
REQ-028 rst_n=0 SHALL immediately (without a clock edge) force state=IDLE, out=0, idx=0, wrap=0, sel_ready=0, and clear the dwell/blank counters.
REQ-029 Reset released mid-scan SHALL restart from IDLE; the scan position is not preserved.

Verification (SEL_W=3, DWELL=2, BLANK=1)
REQ-030 Reset with en=1, mode=1 held -> out=0 while rst_n=0; after release out=00000001 for 2 cycles, 00000000 for 1 cycle, then 00000010.
REQ-031 Direct mode, sel=5 with sel_valid -> next cycle out=00100000, idx=5; sel_valid=0 for 3 cycles -> out holds.
REQ-032 Scan runs a full cycle -> sequence bits 0..7, each for 2 cycles with a 1-cycle zero gap; wrap=1 exactly on the cycle out returns to 00000001.
REQ-033 en dropped during HOLD at idx=3 -> out=0 and idx=0 next cycle; en restored with mode=1 -> restarts at bit 0, wrap=0.
REQ-034 mode 1->0 at idx=6, with sel=2 valid one cycle later -> out=0, then 00000100; sel_ready=0 throughout scan.
REQ-035 BLANK=0 build -> scan outputs are contiguous, with no zero cycle; onehot0(out) is checked every cycle in all tests.
